// File: rtl/cfg_stream_loader.sv
// Configuration-chain transmitter: packs a valid/ready word stream into CFG_HEIGHT-bit columns
// and shifts CFG_WIDTH of them into the fabric under reset. Optional macro CFG_CRC_EN adds a trailing CRC-32 check.
module cfg_stream_loader #(
  parameter int CFG_HEIGHT = 32,
  parameter int CFG_WIDTH  = 8,
  parameter int SRC_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic [SRC_WIDTH-1:0]  src_data,
  output logic                  shift,
  output logic [CFG_HEIGHT-1:0] cdata,
  output logic                  fab_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int WPC = (CFG_HEIGHT + SRC_WIDTH - 1) / SRC_WIDTH;
  localparam int WCW = (WPC > 1) ? $clog2(WPC) : 1;
  localparam logic [WCW-1:0] W_LAST = WCW'(WPC - 1);
  localparam logic [WCW-1:0] W_ONE  = WCW'(1);
  localparam logic [15:0]    C_LAST = 16'(CFG_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SHIFT,
`ifdef CFG_CRC_EN
    S_CHECK,
`endif
    S_FINISH
  } state_t;

  state_t                state;
  logic [WCW-1:0]        word_cnt;
  logic [15:0]           col_cnt;
  logic [CFG_HEIGHT-1:0] col, col_ins;

  // Column register with the current word overlaid at its slot; bits past CFG_HEIGHT simply have no home.
  for (genvar b = 0; b < CFG_HEIGHT; b++) begin : g_col
    assign col_ins[b] = (int'(word_cnt) == b / SRC_WIDTH) ? src_data[b % SRC_WIDTH] : col[b];
  end

`ifdef CFG_CRC_EN
  localparam int NCW = (32 + SRC_WIDTH - 1) / SRC_WIDTH;
  localparam int CCW = (NCW > 1) ? $clog2(NCW) : 1;
  localparam logic [CCW-1:0] K_LAST = CCW'(NCW - 1);
  localparam logic [CCW-1:0] K_ONE  = CCW'(1);

  logic [31:0]    crc, crc_exp, exp_ins;
  logic [CCW-1:0] chk_cnt;

  for (genvar b = 0; b < 32; b++) begin : g_exp
    assign exp_ins[b] = (int'(chk_cnt) == b / SRC_WIDTH) ? src_data[b % SRC_WIDTH] : crc_exp[b];
  end

  // MSB-first, non-reflected CRC-32 over one full source word.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [SRC_WIDTH-1:0] d);
    logic [31:0]          r;
    logic [SRC_WIDTH-1:0] dd;
    r  = c;
    dd = d;
    for (int i = 0; i < SRC_WIDTH; i++) begin
      r  = {r[30:0], 1'b0} ^ ((r[31] ^ dd[SRC_WIDTH-1]) ? 32'h04C11DB7 : 32'h0);
      dd = dd << 1;
    end
    return r;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      src_ready <= 1'b0;
      shift     <= 1'b0;
      cdata     <= '0;
      fab_rst   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      col       <= '0;
      word_cnt  <= '0;
      col_cnt   <= '0;
`ifdef CFG_CRC_EN
      crc       <= '1;
      crc_exp   <= '0;
      chk_cnt   <= '0;
`endif
    end else begin
      shift <= 1'b0;
      done  <= 1'b0;
      // Abort leaves fab_rst untouched so a partial bitstream stays held in reset.
      if (abort && state != S_IDLE) begin
        state     <= S_IDLE;
        src_ready <= 1'b0;
        busy      <= 1'b0;
        err       <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            state     <= S_FILL;
            src_ready <= 1'b1;
            busy      <= 1'b1;
            fab_rst   <= 1'b1;
            err       <= 1'b0;
            word_cnt  <= '0;
            col_cnt   <= '0;
`ifdef CFG_CRC_EN
            crc       <= '1;
            chk_cnt   <= '0;
`endif
          end
          S_FILL: if (src_valid && src_ready) begin
            col <= col_ins;
`ifdef CFG_CRC_EN
            crc <= crc_step(crc, src_data);
`endif
            if (word_cnt == W_LAST) begin
              state     <= S_SHIFT;
              src_ready <= 1'b0;
              shift     <= 1'b1;
              cdata     <= col_ins;
              word_cnt  <= '0;
            end else begin
              word_cnt <= word_cnt + W_ONE;
            end
          end
          S_SHIFT: begin
            col_cnt <= col_cnt + 16'd1;
            if (col_cnt == C_LAST) begin
`ifdef CFG_CRC_EN
              state     <= S_CHECK;
              src_ready <= 1'b1;
`else
              state     <= S_FINISH;
              fab_rst   <= 1'b0;
              done      <= 1'b1;
`endif
            end else begin
              state     <= S_FILL;
              src_ready <= 1'b1;
            end
          end
`ifdef CFG_CRC_EN
          S_CHECK: if (src_valid && src_ready) begin
            crc_exp <= exp_ins;
            if (chk_cnt == K_LAST) begin
              src_ready <= 1'b0;
              if (exp_ins == ~crc) begin
                state   <= S_FINISH;
                fab_rst <= 1'b0;
                done    <= 1'b1;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
                err   <= 1'b1;
              end
            end else begin
              chk_cnt <= chk_cnt + K_ONE;
            end
          end
`endif
          S_FINISH: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cfg_stream_loader.sv
// Directed plus randomized bench for cfg_stream_loader; two instances (32-bit and 20-bit columns).
module tb_cfg_stream_loader;
  localparam int SW  = 16;
  localparam int WPC = 2;
  localparam int HA  = 32, WA = 2;
  localparam int HB  = 20, WB = 1;
  localparam int NCW = 2;
`ifdef CFG_CRC_EN
  localparam bit CRC = 1'b1;
`else
  localparam bit CRC = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b0, sel = 1'b0;
  logic          start = 1'b0, abort = 1'b0, src_valid = 1'b0;
  logic [SW-1:0] src_data = '0;

  logic          a_ready, a_shift, a_fab_rst, a_busy, a_done, a_err;
  logic [HA-1:0] a_cdata;
  logic          b_ready, b_shift, b_fab_rst, b_busy, b_done, b_err;
  logic [HB-1:0] b_cdata;

  logic          rdy, shf, frst, bsy, dn, er;
  logic [31:0]   cd;

  int vec = 0, miss = 0;
  int cyc = 0, n_done = 0, n_frst_low = 0;
  logic [31:0] shq [$];

  always #5 clk = ~clk;

  cfg_stream_loader #(.CFG_HEIGHT(HA), .CFG_WIDTH(WA), .SRC_WIDTH(SW)) u_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .abort(abort & ~sel),
    .src_valid(src_valid & ~sel), .src_ready(a_ready), .src_data(src_data),
    .shift(a_shift), .cdata(a_cdata), .fab_rst(a_fab_rst), .busy(a_busy),
    .done(a_done), .err(a_err));

  cfg_stream_loader #(.CFG_HEIGHT(HB), .CFG_WIDTH(WB), .SRC_WIDTH(SW)) u_b (
    .clk(clk), .rst(rst), .start(start & sel), .abort(abort & sel),
    .src_valid(src_valid & sel), .src_ready(b_ready), .src_data(src_data),
    .shift(b_shift), .cdata(b_cdata), .fab_rst(b_fab_rst), .busy(b_busy),
    .done(b_done), .err(b_err));

  assign rdy  = sel ? b_ready   : a_ready;
  assign shf  = sel ? b_shift   : a_shift;
  assign frst = sel ? b_fab_rst : a_fab_rst;
  assign bsy  = sel ? b_busy    : a_busy;
  assign dn   = sel ? b_done    : a_done;
  assign er   = sel ? b_err     : a_err;
  assign cd   = sel ? {12'h000, b_cdata} : a_cdata;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (shf) shq.push_back(cd);
    if (dn) n_done <= n_done + 1;
    if (bsy && !dn && !frst) n_frst_low <= n_frst_low + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 64'(obs), 64'(exp));
  endtask

  // Reference CRC: the message as one long bit string, divided MSB-first.
  function automatic logic [31:0] crc32(input logic [SW-1:0] m [$]);
    logic [31:0] r;
    bit          bits [$];
    r = 32'hFFFF_FFFF;
    foreach (m[i]) for (int k = SW - 1; k >= 0; k--) bits.push_back(m[i][k]);
    foreach (bits[i]) r = {r[30:0], 1'b0} ^ ((r[31] ^ bits[i]) ? 32'h04C1_1DB7 : 32'h0);
    return ~r;
  endfunction

  task automatic send(input logic [SW-1:0] w, input int stall, input string tag);
    int n = 0;
    while (!rdy && n < 64) begin tick(); n++; end
    chk1({tag, ":ready"}, rdy, 1'b1);
    repeat (stall) tick();
    src_valid = 1'b1;
    src_data  = w;
    tick();
    src_valid = 1'b0;
  endtask

  task automatic load(input int h, input int w, input logic [SW-1:0] wq [$],
                      input int st [$], input bit bad, input string tag);
    logic [SW-1:0] all [$];
    logic [31:0]   c;
    logic [63:0]   e, last;
    int            t0, n, total, nd, nf;
    all = wq;
    c   = crc32(wq);
    if (bad) c[7] = ~c[7];
    if (CRC) begin all.push_back(c[15:0]); all.push_back(c[31:16]); end
    total = 0;
    foreach (st[i]) total += st[i];
    shq.delete();
    nd = n_done;
    nf = n_frst_low;
    start = 1'b1; tick(); start = 1'b0;
    t0 = cyc;
    chk1({tag, ":busy_start"}, bsy, 1'b1);
    chk1({tag, ":fabrst_start"}, frst, 1'b1);
    chk1({tag, ":err_start"}, er, 1'b0);
    foreach (all[i]) send(all[i], (i < st.size()) ? st[i] : 0, tag);
    if (bad) begin
      chk1({tag, ":err_bad"}, er, 1'b1);
      chk1({tag, ":fabrst_bad"}, frst, 1'b1);
      chk1({tag, ":busy_bad"}, bsy, 1'b0);
    end else begin
      n = 0;
      while (!dn && n < 100) begin tick(); n++; end
      chk1({tag, ":done_seen"}, dn, 1'b1);
      // Load time is W*(WPC+1)+1 cycles counting the start cycle, plus CRC words and stalls.
      chk({tag, ":done_cyc"}, 64'(cyc - t0), 64'(w * (WPC + 1) + (CRC ? NCW : 0) + total));
      chk1({tag, ":fabrst_done"}, frst, 1'b0);
      chk1({tag, ":err_done"}, er, 1'b0);
    end
    tick();
    chk1({tag, ":busy_end"}, bsy, 1'b0);
    chk1({tag, ":done_end"}, dn, 1'b0);
    chk({tag, ":done_cnt"}, 64'(n_done - nd), bad ? 64'd0 : 64'd1);
    chk({tag, ":fabrst_low"}, 64'(n_frst_low - nf), 64'd0);
    chk({tag, ":shift_cnt"}, 64'(shq.size()), 64'(w));
    last = '0;
    for (int k = 0; k < w; k++) begin
      e = '0;
      for (int j = 0; j < WPC; j++) e = e | (64'(wq[k*WPC+j]) << (j * SW));
      e = e & ((64'd1 << h) - 64'd1);
      if (k < shq.size()) chk({tag, ":col"}, 64'(shq[k]), e);
      last = e;
    end
    chk({tag, ":cdata_hold"}, 64'(cd), last);
  endtask

  initial begin
    logic [SW-1:0] q [$];
    int            s [$];
    int            nd;

    // Reset values
    #2;
    chk1("rst:ready", rdy, 1'b0);  chk1("rst:shift", shf, 1'b0);
    chk("rst:cdata", 64'(cd), 64'd0);
    chk1("rst:fabrst", frst, 1'b0); chk1("rst:busy", bsy, 1'b0);
    chk1("rst:done", dn, 1'b0);     chk1("rst:err", er, 1'b0);
    chk1("rst:b_busy", b_busy, 1'b0); chk("rst:b_cdata", 64'(b_cdata), 64'd0);
    #6 rst = 1'b1;
    tick();

    // Basic two-column load
    q.delete(); s.delete();
    q.push_back(16'h0000); q.push_back(16'hffff); q.push_back(16'h5555); q.push_back(16'h5555);
    repeat (4) s.push_back(0);
    load(HA, WA, q, s, 1'b0, "t1");
    chk("t1:col0_const", 64'(shq[0]), 64'hffff_0000);
    chk("t1:col1_const", 64'(shq[1]), 64'h5555_5555);

    // Five-cycle source stall inside the second column
    s.delete(); s.push_back(0); s.push_back(0); s.push_back(0); s.push_back(5);
    load(HA, WA, q, s, 1'b0, "t2");

    // Abort one cycle after the first shift
    shq.delete(); nd = n_done;
    start = 1'b1; tick(); start = 1'b0;
    send(16'h1111, 0, "t3"); send(16'h2222, 0, "t3");
    chk1("t3:shift1", shf, 1'b1);
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk1("t3:busy", bsy, 1'b0);  chk1("t3:err", er, 1'b1);
    chk1("t3:fabrst", frst, 1'b1); chk1("t3:ready", rdy, 1'b0);
    repeat (8) tick();
    chk("t3:shift_cnt", 64'(shq.size()), 64'd1);
    chk("t3:no_done", 64'(n_done - nd), 64'd0);
    chk1("t3:err_sticky", er, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    chk1("t3:err_clr", er, 1'b0);
    abort = 1'b1; tick(); abort = 1'b0;

    // Abort coinciding with the final shift
    shq.delete(); nd = n_done;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) send(16'($urandom), 0, "tfa");
    chk1("tfa:final_shift", shf, 1'b1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk1("tfa:busy", bsy, 1'b0); chk1("tfa:err", er, 1'b1); chk1("tfa:fabrst", frst, 1'b1);
    repeat (6) tick();
    chk("tfa:no_done", 64'(n_done - nd), 64'd0);
    chk("tfa:shift_cnt", 64'(shq.size()), 64'd2);

    // Asynchronous reset while filling column 1
    start = 1'b1; tick(); start = 1'b0;
    send(16'haaaa, 0, "t4"); send(16'hbbbb, 0, "t4"); send(16'hcccc, 0, "t4");
    #2 rst = 1'b0;
    #1;
    chk1("t4:ready", rdy, 1'b0); chk1("t4:shift", shf, 1'b0);
    chk("t4:cdata", 64'(cd), 64'd0);
    chk1("t4:fabrst", frst, 1'b0); chk1("t4:busy", bsy, 1'b0);
    chk1("t4:done", dn, 1'b0);     chk1("t4:err", er, 1'b0);
    #1 rst = 1'b1;
    tick();
    q.delete(); s.delete();
    for (int i = 0; i < 4; i++) begin q.push_back(16'($urandom)); s.push_back(0); end
    load(HA, WA, q, s, 1'b0, "t4r");

    // 20-bit column: upper bits of the second word are dropped
    sel = 1'b1;
    q.delete(); s.delete();
    q.push_back(16'habcd); q.push_back(16'h1234); s.push_back(0); s.push_back(0);
    load(HB, WB, q, s, 1'b0, "t5");
    chk("t5:const", 64'(shq[0]), 64'h4abcd);

`ifdef CFG_CRC_EN
    // Corrupted trailing CRC
    sel = 1'b0;
    q.delete(); s.delete();
    for (int i = 0; i < 4; i++) begin q.push_back(16'($urandom)); s.push_back(0); end
    load(HA, WA, q, s, 1'b1, "t6bad");
`endif

    // Randomized loads with random stalls on both instances
    for (int it = 0; it < 8; it++) begin
      sel = it[0];
      q.delete(); s.delete();
      for (int i = 0; i < WPC * (sel ? WB : WA); i++) begin
        q.push_back(16'($urandom));
        s.push_back(int'($urandom_range(0, 3)));
      end
      load(sel ? HB : HA, sel ? WB : WA, q, s, 1'b0, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/cfg_stream_loader.md
Name: cfg_stream_loader

Overview:
- Transmitter end of the fabric configuration chain. Drives the `fpga` block's `shift`/`cdata` inputs and its `rst`.
- Consumes a valid/ready word stream (boot ROM or PCPI-side DMA) and packs words into CFG_HEIGHT-bit columns.
- Shifts exactly CFG_WIDTH columns into the fabric, holding the fabric in reset throughout.
- Replaces the bench-only bitstream load task for on-chip reconfiguration.

Parameters:
- CFG_HEIGHT, 32: column height in bits; width of cdata.
- CFG_WIDTH, 8: number of columns per bitstream; legal range 1 to 65535.
- SRC_WIDTH, 16: input word width; WPC = ceil(CFG_HEIGHT/SRC_WIDTH) words per column.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a load; sampled in IDLE only
- abort  in  1  cancel the current load
- src_valid  in  1  source word valid
- src_ready  out  1  loader accepts the word this cycle
- src_data  in  SRC_WIDTH  source word
- shift  out  1  fabric shift strobe, registered
- cdata  out  CFG_HEIGHT  fabric column data, registered
- fab_rst  out  1  fabric reset, active-high, registered
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky error; cleared by the next accepted start

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; src_ready=0, shift=0, cdata=0, fab_rst=0, busy=0, done=0, err=0; column and word counters = 0.
- IDLE:
  - start=1 → FILL. Clear counters, clear err, fab_rst=1.
  - start while busy is ignored.
- FILL:
  - src_ready=1.
  - Each handshake (src_valid & src_ready) writes src_data into the column register at bit offset word_cnt*SRC_WIDTH, LSB first.
  - Bits beyond CFG_HEIGHT in the last word are discarded.
  - On the WPC-th handshake → SHIFT. src_ready drops in that same cycle's next state.
- SHIFT (exactly 1 cycle):
  - shift=1, cdata=assembled column; src_ready=0.
  - col_cnt increments.
  - If col_cnt was CFG_WIDTH-1 → FINISH, else → FILL with word_cnt=0.
  - Columns go out in stream order; the first column shifted ends deepest in the chain.
- FINISH (1 cycle): fab_rst=0, done=1 → IDLE. Without CRC, fab_rst falls in the same cycle done rises.
- Outside SHIFT: shift=0 and cdata holds its last value.
- Latency, no backpressure and WPC=2: column k's shift asserts 1 cycle after its 2nd handshake. Total load time = CFG_WIDTH*(WPC+1)+1 cycles from start to done.
- Source stalls (src_valid=0) hold FILL indefinitely; there is no timeout.
- Abort:
  - In any non-IDLE state → IDLE next cycle; err=1, fab_rst stays 1, no further shift.
  - If abort and the final SHIFT coincide, abort wins: no done, err=1.
- A partially loaded fabric is left in reset until a later successful load.
- Reset mid-load: immediate return to reset values. fab_rst drops to 0; the integrator must gate fabric use on done.

Optional Feature:
- Macro: CFG_CRC_EN.
- Defined:
  - A CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, no reflection, final XOR 0xFFFFFFFF) accumulates over every accepted word's full SRC_WIDTH bits, in order.
  - After the last SHIFT the state goes to CHECK instead of FINISH. CHECK accepts ceil(32/SRC_WIDTH) further words, LSB first, as the expected CRC.
  - Match → FINISH.
  - Mismatch → IDLE with err=1, fab_rst held at 1, no done.
- Undefined: no CRC logic, no CHECK state; the stream ends at the last column word.

Test Plan:
1. CFG_HEIGHT=32, SRC_WIDTH=16, CFG_WIDTH=2; words 0x0000,0xffff,0x5555,0x5555 → shift pulses carry cdata 0xffff0000 then 0x55555555. done at cycle 7 after start; fab_rst high for cycles 1-6.
2. Same config, src_valid low for 5 cycles between words 2 and 3 → no shift during the stall; shift count is still 2; done delayed by exactly 5 cycles.
3. Assert abort one cycle after the first shift → no second shift; busy=0 next cycle; err=1; fab_rst=1; done never pulses. A new start clears err.
4. Pulse rst low during FILL of column 1 → all outputs 0 asynchronously. A fresh start with 4 words completes normally with correct cdata.
5. CFG_HEIGHT=20, SRC_WIDTH=16, CFG_WIDTH=1; words 0xabcd,0x1234 → cdata=0x4abcd (bits 19:16 = 0x4, upper word bits 15:4 dropped).
6. With CFG_CRC_EN: correct trailing CRC words → done=1, err=0. One CRC bit flipped → done=0, err=1, fab_rst stays 1.
